// File: rtl/life_gen_engine.sv
// life_gen_engine: streams one Game-of-Life generation in raster order and emits the next one,
// using two row delay lines and a 3x3 window; off-board cells are dead.
module life_gen_engine #(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_cell,
  input  logic in_sof,
  output logic out_valid,
  output logic out_cell,
  output logic out_sof,
  output logic busy
);
  localparam int FW = $clog2(X + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [X-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [2:0] t_q, t_d, m_q, m_d, b_q, b_d;
  logic [LOG2X-1:0] col_q, col_d, cj;
  logic [LOG2Y-1:0] row_q, row_d;
  logic [FW-1:0] fl_q, fl_d;
  logic valid_q, cell_q, sof_q;
  logic acc, restart, shift, x, d1o, d2o, col_w, last, emit, sof_d, lm, rm;
  logic [3:0] n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = restart ? RUN :
              (state_q == RUN && acc && last) ? FLUSH :
              (state_q == FLUSH && fl_q == FW'(X)) ? IDLE : state_q;
  always_comb begin
    in_ready = state_q != FLUSH;
    busy = state_q != IDLE;
  end
  assign acc = in_valid & in_ready;
  assign restart = acc & in_sof;
  assign shift = restart | (state_q == RUN && acc) | (state_q == FLUSH);
  assign x = (state_q == FLUSH) ? 1'b0 : in_cell;
  assign d1o = restart ? 1'b0 : d1_q[X-1];
  assign d2o = restart ? 1'b0 : d2_q[X-1];
  assign col_w = col_q == LOG2X'(X - 1);
  assign last = row_q == LOG2Y'(Y - 1) && col_w;
  always_comb begin
    d1_d = shift ? {restart ? (X-1)'(0) : d1_q[X-2:0], x} : d1_q;
    d2_d = shift ? {restart ? (X-1)'(0) : d2_q[X-2:0], d1o} : d2_q;
    t_d = shift ? {restart ? 2'b0 : t_q[1:0], d2o} : t_q;
    m_d = shift ? {restart ? 2'b0 : m_q[1:0], d1o} : m_q;
    b_d = shift ? {restart ? 2'b0 : b_q[1:0], x} : b_q;
    col_d = restart ? LOG2X'(1) : shift ? (col_w ? '0 : col_q + 1'b1) : col_q;
    row_d = restart ? '0 : (shift && col_w) ? row_q + 1'b1 : row_q;
    fl_d = restart ? '0 : (state_q == FLUSH) ? fl_q + 1'b1 : fl_q;
  end
  // The centre cell lags the newest input by X+1, so it sits one column left of col_q.
  always_comb begin
    emit = state_q == FLUSH ||
           (state_q == RUN && acc && !in_sof &&
            (row_q > LOG2Y'(1) || (row_q == LOG2Y'(1) && col_q != '0)));
    sof_d = state_q == RUN && acc && !in_sof && row_q == LOG2Y'(1) && col_q == LOG2X'(1);
    cj = (col_q == '0) ? LOG2X'(X - 1) : col_q - 1'b1;
    lm = cj != '0;
    rm = cj != LOG2X'(X - 1);
    n = 4'(t_d[2] & lm) + 4'(t_d[1]) + 4'(t_d[0] & rm) +
        4'(m_d[2] & lm) + 4'(m_d[0] & rm) +
        4'(b_d[2] & lm) + 4'(b_d[1]) + 4'(b_d[0] & rm);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      d1_q <= '0;
      d2_q <= '0;
      t_q <= '0;
      m_q <= '0;
      b_q <= '0;
      col_q <= '0;
      row_q <= '0;
      fl_q <= '0;
      valid_q <= 1'b0;
      cell_q <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
      t_q <= t_d;
      m_q <= m_d;
      b_q <= b_d;
      col_q <= col_d;
      row_q <= row_d;
      fl_q <= fl_d;
      valid_q <= emit;
      cell_q <= emit & ((n == 4'd3) | (m_d[1] & (n == 4'd2)));
      sof_q <= sof_d;
    end
  assign out_valid = valid_q;
  assign out_cell = cell_q;
  assign out_sof = sof_q;
endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: scoreboard bench; a reference Life model queues the expected stream per frame.
module tb_life_gen_engine;
  localparam int X = 8;
  localparam int Y = 8;
  localparam int N = X * Y;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_cell, in_sof, out_valid, out_cell, out_sof, busy;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int sb[$];
  always #5 clk = ~clk;
  life_gen_engine #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cell(in_cell), .in_sof(in_sof), .out_valid(out_valid), .out_cell(out_cell),
    .out_sof(out_sof), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] r;
    int n, rr, cc;
    r = '0;
    for (int y = 0; y < Y; y++)
      for (int x = 0; x < X; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            rr = y + dy;
            cc = x + dx;
            if ((dy != 0 || dx != 0) && rr >= 0 && rr < Y && cc >= 0 && cc < X)
              n += int'(b[rr*X+cc]);
          end
        r[y*X+x] = (n == 3) || (b[y*X+x] && n == 2);
      end
    return r;
  endfunction
  always @(negedge clk)
    if (out_valid) begin
      pulses++;
      if (sb.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        int e;
        e = sb.pop_front();
        check($sformatf("out_cell j=%0d", e >> 2), out_cell, e & 1);
        check($sformatf("out_sof j=%0d", e >> 2), out_sof, (e >> 1) & 1);
      end
    end
  task automatic drive_cell(input logic c, input logic s, input bit gaps);
    int t;
    if (gaps)
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    in_valid = 1'b1;
    in_cell = c;
    in_sof = s;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask
  task automatic send_frame(input logic [N-1:0] b, input bit gaps, input int ncells, input bit wait_flush);
    logic [N-1:0] nx;
    int ne, cnt;
    nx = life(b);
    ne = (ncells == N) ? N : ncells - (X + 1);
    for (int j = 0; j < ne; j++) sb.push_back(j * 4 + ((j == 0) ? 2 : 0) + int'(nx[j]));
    for (int k = 0; k < ncells; k++) begin
      drive_cell(b[k], k == 0, gaps);
      if (k == 0) check("busy_run", busy, 1);
      if (!gaps && k == X) check("pre_first_valid", out_valid, 0);
      if (!gaps && k == X + 1) begin
        check("first_valid", out_valid, 1);
        check("first_sof", out_sof, 1);
      end
    end
    if (wait_flush) begin
      cnt = 0;
      while (busy && cnt < 100) begin
        cnt++;
        @(posedge clk); #1;
      end
      check("flush_len", cnt, X + 1);
      @(negedge clk); #1;
    end
  endtask
  initial begin
    logic [N-1:0] blinker, block, corner, col7, glider;
    blinker = '0; blinker[26] = 1; blinker[27] = 1; blinker[28] = 1;
    block = '0; block[9] = 1; block[10] = 1; block[17] = 1; block[18] = 1;
    corner = '0; corner[0] = 1; corner[1] = 1; corner[8] = 1;
    col7 = '0; col7[7] = 1; col7[15] = 1; col7[23] = 1;
    glider = '0; glider[10] = 1; glider[19] = 1; glider[25] = 1; glider[26] = 1; glider[27] = 1;
    reset = 1'b0;
    in_valid = 1'b0;
    in_cell = 1'b0;
    in_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_cell", out_cell, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    pulses = 0; send_frame(blinker, 0, N, 1); check("pulses_blinker", pulses, N);
    pulses = 0; send_frame(block, 0, N, 1); check("pulses_block", pulses, N);
    pulses = 0; send_frame(corner, 0, N, 1); check("pulses_corner", pulses, N);
    pulses = 0; send_frame(col7, 0, N, 1); check("pulses_col7", pulses, N);
    pulses = 0; send_frame(glider, 1, N, 1); check("pulses_glider_gaps", pulses, N);
    pulses = 0; send_frame(glider, 0, N, 1); check("pulses_glider", pulses, N);
    pulses = 0;
    send_frame(glider, 0, 20, 0);
    send_frame('0, 0, N, 1);
    check("pulses_abort", pulses, 11 + N);
    send_frame(blinker, 0, N, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rstflush_out_valid", out_valid, 0);
    check("rstflush_busy", busy, 0);
    check("rstflush_out_sof", out_sof, 0);
    sb.delete();
    #2 reset = 1'b1;
    #1 check("rstflush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    pulses = 0; send_frame(blinker, 0, N, 1); check("pulses_after_reset", pulses, N);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
Consumes one Game-of-Life generation as a serial raster cell stream (row 0 first, column 0 first in each row, one bit per cell) and emits the next generation as a serial raster stream.
- Two internal X-deep row delay lines plus a 3x3 window supply each cell's eight neighbours.
- Cells outside the X-by-Y board are dead; there is no wrap-around.
- Sits downstream of the board's serial cell pipe, reading what that pipe writes.

Parameters:
X, 8, board width in cells (X >= 3)
Y, 8, board height in cells (Y >= 3)
LOG2X, 3, column counter width, ceil(log2(X))
LOG2Y, 3, row counter width, ceil(log2(Y))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  in_cell/in_sof are valid this cycle
in_ready  output  1  engine accepts input this cycle
in_cell  input  1  current-generation cell, 1 = alive
in_sof  input  1  marks cell (0,0) of a frame
out_valid  output  1  out_cell/out_sof valid this cycle (single-cycle pulse, no backpressure)
out_cell  output  1  next-generation cell
out_sof  output  1  marks output cell (0,0)
busy  output  1  frame in progress (RUN or FLUSH)

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - Outputs: out_valid=0, out_cell=0, out_sof=0, busy=0, in_ready=1.
  - State: IDLE, all counters 0, delay lines and window cleared to 0.
- Accept: a transfer occurs when in_valid & in_ready. Input index k = r*X+c counts accepted cells, 0..X*Y-1.
- States:
  - IDLE: in_ready=1. Non-SOF inputs are accepted and dropped. An accepted in_sof clears delay lines, window and counters, takes cell as k=0, and goes to RUN.
  - RUN: in_ready=1. Each accepted cell shifts into window and delay lines. After k = X*Y-1 is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Injects one dead virtual cell per cycle for X+1 cycles (k = X*Y .. X*Y+X), then returns to IDLE.
- Output timing:
  - Output index j = k-(X+1) is produced for every accepted or virtual k >= X+1.
  - out_valid rises exactly 1 cycle after the cycle k is taken.
  - Exactly X*Y out_valid pulses per frame, in raster order.
  - out_sof=1 only with j=0.
- Next-state rule: n = count of the 8 neighbours. out_cell = (n==3) | (centre & n==2).
- Boundary masking:
  - Column 0: left-column neighbours forced dead. Column X-1: right-column neighbours forced dead.
  - Row 0 above-neighbours are dead, because delay lines are cleared at SOF.
  - Row Y-1 below-neighbours are dead, supplied by the FLUSH virtual cells.
- Gaps: in_valid low during RUN stalls the pipeline; no output that cycle, no state change.
- in_sof during RUN with k != 0 aborts the current frame:
  - No flush, no further outputs for the old frame.
  - The new frame restarts at k=0 the same cycle.
  - The first output of the new frame is still at k=X+1.
- in_sof during FLUSH is not possible (in_ready=0); the source holds it.
- in_sof while the engine is in IDLE is accepted immediately.
- busy = (state != IDLE). It goes 0 the cycle after the last virtual cell; the last out_valid appears that same cycle.
- Counter widths: column 0..X-1 wraps to 0 and increments row; flush counter 0..X.
- Reset mid-frame: all state is discarded immediately and out_valid drops asynchronously.

Test Plan:
- 8x8 blinker: input alive at k=26,27,28, continuous valid → outputs alive exactly at j=19,27,35; 64 out_valid pulses; first pulse 1 cycle after k=9 accepted; out_sof with j=0.
- 8x8 block at k=9,10,17,18 → output identical (j=9,10,17,18 alive), all others 0.
- Corner/edge masking: alive at k=0,1,8 → j=0,1,8,9 alive (still-life block formed); alive at k=7,15,23 (column 7) → only j=14,15 alive, nothing in column 0 of the next row.
- Random in_valid gaps (50% duty) with 8x8 glider → same output sequence as the gap-free run; pulse count 64; busy falls after the FLUSH of 9 cycles.
- Mid-frame abort: in_sof at k=20 of frame A, then full frame B all-dead → at most 11 outputs from A (j=0..10), then exactly 64 zero outputs for B, out_sof asserted at B's j=0.
- Reset asserted during FLUSH → out_valid, busy, out_sof go 0 immediately; in_ready=1 after release; the next full frame behaves like the blinker case.
